// File: rtl/servo_pwm_driver.sv
// Frame-synchronous pan/tilt servo PWM generator driven by level commands from the AHB servo registers.
// Optional SERVO_SOFT_HOME_EN makes the HOME mode slew to centre instead of jumping there.
module servo_pwm_driver #(
    parameter int PRESCALE  = 50,
    parameter int PERIOD_US = 20000,
    parameter int MIN_US    = 500,
    parameter int MAX_US    = 2500,
    parameter int CENTER_US = 1500,
    parameter int STEP_US   = 10
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        Servo_up,
    input  logic        Servo_down,
    input  logic        Servo_left,
    input  logic        Servo_right,
    input  logic        Servo_rst,
    input  logic        Servo_track_en,
    input  logic        trk_valid,
    input  logic [11:0] trk_pan_us,
    input  logic [11:0] trk_tilt_us,
    output logic        pwm_pan,
    output logic        pwm_tilt,
    output logic [11:0] pan_us,
    output logic [11:0] tilt_us,
    output logic        frame_start,
    output logic [1:0]  mode_dbg
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [15:0]   FC_LAST  = 16'(PERIOD_US - 1);

    localparam logic [11:0] CENTER_P = 12'(CENTER_US);
    localparam logic [11:0] MIN_P    = 12'(MIN_US);
    localparam logic [11:0] MAX_P    = 12'(MAX_US);

    localparam logic signed [12:0] STEP_S = 13'(STEP_US);
    localparam logic signed [12:0] MIN_S  = 13'(MIN_US);
    localparam logic signed [12:0] MAX_S  = 13'(MAX_US);

    localparam logic [1:0] MODE_MANUAL = 2'd0;
    localparam logic [1:0] MODE_TRACK  = 2'd1;
    localparam logic [1:0] MODE_HOME   = 2'd2;

    logic [PW-1:0] pre;
    logic [15:0]   fc;
    logic          started;
    logic          us_tick;
    logic          fc_wrap;

    logic [11:0]   wpan;
    logic [11:0]   wtilt;
    logic [11:0]   tgt_pan;
    logic [11:0]   tgt_tilt;
    logic [1:0]    mode;
    logic [1:0]    mode_nxt;
    logic [11:0]   pan_nxt;
    logic [11:0]   tilt_nxt;

    function automatic logic [11:0] clamp_pos(input logic signed [12:0] v);
        if (v < MIN_S)
            return MIN_P;
        else if (v > MAX_S)
            return MAX_P;
        else
            return v[11:0];
    endfunction

    function automatic logic [11:0] clamp_tgt(input logic [11:0] v);
        if (v < MIN_P)
            return MIN_P;
        else if (v > MAX_P)
            return MAX_P;
        else
            return v;
    endfunction

    // Move toward tgt by at most STEP_US; the limited delta can never overshoot.
    function automatic logic [11:0] step_toward(input logic [11:0] pos, input logic [11:0] tgt);
        logic signed [12:0] d;
        d = $signed({1'b0, tgt}) - $signed({1'b0, pos});
        if (d > STEP_S)
            d = STEP_S;
        else if (d < -STEP_S)
            d = -STEP_S;
        return clamp_pos($signed({1'b0, pos}) + d);
    endfunction

    function automatic logic [11:0] manual_step(input logic [11:0] pos, input logic inc,
                                                input logic dec);
        logic signed [12:0] d;
        d = '0;
        if (inc && !dec)
            d = STEP_S;
        else if (dec && !inc)
            d = -STEP_S;
        return clamp_pos($signed({1'b0, pos}) + d);
    endfunction

    assign us_tick  = (pre == PRE_LAST);
    assign fc_wrap  = us_tick && (fc == FC_LAST);
    assign mode_dbg = mode;

    // frame_start is registered: it is high during the first HCLK of the frame (fc == 0).
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pre         <= '0;
            fc          <= '0;
            started     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pre <= us_tick ? '0 : pre + 1'b1;
            if (us_tick)
                fc <= fc_wrap ? '0 : fc + 16'd1;
            started     <= 1'b1;
            frame_start <= fc_wrap || !started;
        end
    end

    // trk_valid is a single-cycle strobe with no back-pressure; targets are stored pre-clamped.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            tgt_pan  <= CENTER_P;
            tgt_tilt <= CENTER_P;
        end else if (trk_valid) begin
            tgt_pan  <= clamp_tgt(trk_pan_us);
            tgt_tilt <= clamp_tgt(trk_tilt_us);
        end
    end

    always_comb begin
        mode_nxt = mode;
        pan_nxt  = pan_us;
        tilt_nxt = tilt_us;
        if (Servo_rst)
            mode_nxt = MODE_HOME;
        else if ((mode == MODE_HOME) && !((pan_us == CENTER_P) && (tilt_us == CENTER_P)))
            mode_nxt = MODE_HOME;
        else if (Servo_track_en)
            mode_nxt = MODE_TRACK;
        else
            mode_nxt = MODE_MANUAL;

        case (mode_nxt)
            MODE_HOME: begin
`ifdef SERVO_SOFT_HOME_EN
                pan_nxt  = step_toward(pan_us, CENTER_P);
                tilt_nxt = step_toward(tilt_us, CENTER_P);
`else
                pan_nxt  = CENTER_P;
                tilt_nxt = CENTER_P;
`endif
            end
            MODE_TRACK: begin
                pan_nxt  = step_toward(pan_us, tgt_pan);
                tilt_nxt = step_toward(tilt_us, tgt_tilt);
            end
            default: begin
                pan_nxt  = manual_step(pan_us, Servo_right, Servo_left);
                tilt_nxt = manual_step(tilt_us, Servo_up, Servo_down);
            end
        endcase
    end

    // Shadow widths are latched before the position update, so a new position shows one frame later.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            mode     <= MODE_MANUAL;
            pan_us   <= CENTER_P;
            tilt_us  <= CENTER_P;
            wpan     <= CENTER_P;
            wtilt    <= CENTER_P;
            pwm_pan  <= 1'b0;
            pwm_tilt <= 1'b0;
        end else begin
            pwm_pan  <= (fc < {4'b0, wpan});
            pwm_tilt <= (fc < {4'b0, wtilt});
            if (frame_start) begin
                wpan    <= pan_us;
                wtilt   <= tilt_us;
                pan_us  <= pan_nxt;
                tilt_us <= tilt_nxt;
                mode    <= mode_nxt;
            end
        end
    end

endmodule

// File: tb/tb_servo_pwm_driver.sv
// Directed bench for servo_pwm_driver with small parameters; per-frame expectations go through a queue.
module tb_servo_pwm_driver;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        Servo_up, Servo_down, Servo_left, Servo_right, Servo_rst, Servo_track_en;
    logic        trk_valid;
    logic [11:0] trk_pan_us, trk_tilt_us;
    logic        pwm_pan, pwm_tilt, frame_start;
    logic [11:0] pan_us, tilt_us;
    logic [1:0]  mode_dbg;

    int total = 0;
    int bad   = 0;
    int frame_no = 0;

    // entry: {pan, tilt, pan_width, tilt_width, frame_len, mode}
    logic [49:0] exp_q[$];

    servo_pwm_driver #(
        .PRESCALE(2), .PERIOD_US(100), .MIN_US(10), .MAX_US(50), .CENTER_US(30), .STEP_US(5)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .Servo_up(Servo_up), .Servo_down(Servo_down), .Servo_left(Servo_left),
        .Servo_right(Servo_right), .Servo_rst(Servo_rst), .Servo_track_en(Servo_track_en),
        .trk_valid(trk_valid), .trk_pan_us(trk_pan_us), .trk_tilt_us(trk_tilt_us),
        .pwm_pan(pwm_pan), .pwm_tilt(pwm_tilt), .pan_us(pan_us), .tilt_us(tilt_us),
        .frame_start(frame_start), .mode_dbg(mode_dbg)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s frame=%0d observed=%0d expected=%0d", tag, frame_no, obs, exp);
        end
    endtask

    task automatic push_exp(input int p, input int t, input int wp, input int wt,
                            input int len, input int m);
        exp_q.push_back({12'(p), 12'(t), 8'(wp), 8'(wt), 8'(len), 2'(m)});
    endtask

    task automatic skip_to_frame_start();
        for (int i = 0; i < 400; i++) begin
            if (frame_start) break;
            @(negedge HCLK);
        end
        check("sync_frame_start", {31'b0, frame_start}, 32'd1);
    endtask

    // Called at the negedge of a frame_start cycle; returns at the next one.
    task automatic measure_frame();
        int len, cp, ct;
        logic [11:0] sp, st;
        logic [1:0]  sm;
        logic [49:0] e;
        len = 0; cp = 0; ct = 0;
        sp = 'x; st = 'x; sm = 'x;
        do begin
            if (pwm_pan) cp++;
            if (pwm_tilt) ct++;
            len++;
            @(negedge HCLK);
            trk_valid = 1'b0;
            if (len == 1) begin
                sp = pan_us;
                st = tilt_us;
                sm = mode_dbg;
            end
        end while (!frame_start && len < 400);
        frame_no++;
        if (exp_q.size() == 0) begin
            check("queue_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("pan_us", {20'b0, sp}, {20'b0, e[49:38]});
            check("tilt_us", {20'b0, st}, {20'b0, e[37:26]});
            check("pan_width", 32'(cp), {24'b0, e[25:18]});
            check("tilt_width", 32'(ct), {24'b0, e[17:10]});
            check("frame_len", 32'(len), {24'b0, e[9:2]});
            check("mode", {30'b0, sm}, {30'b0, e[1:0]});
        end
    endtask

    initial begin
        HRESETn = 1'b0;
        Servo_up = 0; Servo_down = 0; Servo_left = 0; Servo_right = 0;
        Servo_rst = 0; Servo_track_en = 0;
        trk_valid = 0; trk_pan_us = '0; trk_tilt_us = '0;
        repeat (3) @(negedge HCLK);

        check("rst_pwm_pan", {31'b0, pwm_pan}, 32'd0);
        check("rst_pwm_tilt", {31'b0, pwm_tilt}, 32'd0);
        check("rst_frame_start", {31'b0, frame_start}, 32'd0);
        check("rst_pan_us", {20'b0, pan_us}, 32'd30);
        check("rst_tilt_us", {20'b0, tilt_us}, 32'd30);
        check("rst_mode", {30'b0, mode_dbg}, 32'd0);

        // idle frames: first frame_start one cycle after release, then every 200 HCLK
        HRESETn = 1'b1;
        @(negedge HCLK);
        check("fs_after_reset", {31'b0, frame_start}, 32'd1);
        push_exp(30, 30, 60, 60, 199, 0);
        push_exp(30, 30, 60, 60, 200, 0);
        push_exp(30, 30, 60, 60, 200, 0);
        repeat (3) measure_frame();

        // tilt up saturating at MAX
        Servo_up = 1;
        push_exp(30, 35, 60, 60, 200, 0);
        push_exp(30, 40, 60, 70, 200, 0);
        push_exp(30, 45, 60, 80, 200, 0);
        push_exp(30, 50, 60, 90, 200, 0);
        push_exp(30, 50, 60, 100, 200, 0);
        push_exp(30, 50, 60, 100, 200, 0);
        repeat (6) measure_frame();

        // up+down cancel, left alone saturates at MIN
        Servo_down = 1; Servo_left = 1;
        push_exp(25, 50, 60, 100, 200, 0);
        push_exp(20, 50, 50, 100, 200, 0);
        push_exp(15, 50, 40, 100, 200, 0);
        push_exp(10, 50, 30, 100, 200, 0);
        push_exp(10, 50, 20, 100, 200, 0);
        repeat (5) measure_frame();

        // async reset in the middle of a pulse
        Servo_up = 0; Servo_down = 0; Servo_left = 0;
        repeat (10) @(negedge HCLK);
        check("mid_pwm_pan_high", {31'b0, pwm_pan}, 32'd1);
        check("mid_pwm_tilt_high", {31'b0, pwm_tilt}, 32'd1);
        HRESETn = 1'b0;
        #1;
        check("abort_pwm_pan", {31'b0, pwm_pan}, 32'd0);
        check("abort_pwm_tilt", {31'b0, pwm_tilt}, 32'd0);
        check("abort_pan_us", {20'b0, pan_us}, 32'd30);
        check("abort_tilt_us", {20'b0, tilt_us}, 32'd30);
        check("abort_frame_start", {31'b0, frame_start}, 32'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);
        check("fs_after_rerelease", {31'b0, frame_start}, 32'd1);
        push_exp(30, 30, 60, 60, 199, 0);
        measure_frame();

        // tracking with clamped tilt target
        @(negedge HCLK);
        trk_pan_us = 12'd47; trk_tilt_us = 12'd3; trk_valid = 1;
        @(negedge HCLK);
        trk_valid = 0;
        skip_to_frame_start();
        Servo_track_en = 1;
        push_exp(35, 25, 60, 60, 200, 1);
        push_exp(40, 20, 70, 50, 200, 1);
        push_exp(45, 15, 80, 40, 200, 1);
        push_exp(47, 10, 90, 30, 200, 1);
        push_exp(47, 10, 94, 20, 200, 1);
        repeat (5) measure_frame();

        // HOME overrides tracking
        Servo_rst = 1;
`ifdef SERVO_SOFT_HOME_EN
        push_exp(42, 15, 94, 20, 200, 2);
        push_exp(37, 20, 84, 30, 200, 2);
        push_exp(32, 25, 74, 40, 200, 2);
        push_exp(30, 30, 64, 50, 200, 2);
`else
        push_exp(30, 30, 94, 20, 200, 2);
        push_exp(30, 30, 60, 60, 200, 2);
        push_exp(30, 30, 60, 60, 200, 2);
        push_exp(30, 30, 60, 60, 200, 2);
`endif
        repeat (4) measure_frame();
        Servo_rst = 0; Servo_track_en = 0;
        push_exp(30, 30, 60, 60, 200, 0);
        measure_frame();

        // trk_valid on the frame_start cycle: old targets (47/10) used this frame, new ones next
        Servo_track_en = 1;
        trk_pan_us = 12'd20; trk_tilt_us = 12'd40; trk_valid = 1;
        push_exp(35, 25, 60, 60, 200, 1);
        push_exp(30, 30, 70, 50, 200, 1);
        push_exp(25, 35, 60, 60, 200, 1);
        push_exp(20, 40, 50, 70, 200, 1);
        push_exp(20, 40, 40, 80, 200, 1);
        repeat (5) measure_frame();

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
